// File: rtl/fetch_redirect_unit.sv
// Fetch PC generator with a two-deep prediction tracker (ID, EXE) that compares
// each resolved branch against the prediction it was fetched with and redirects fetch.
module fetch_redirect_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] pc_if,
  input  logic                  jump_if,
  input  logic [ADDR_WIDTH-1:0] pc_target_if,
  input  logic [ADDR_WIDTH-1:0] pc_exe,
  input  logic                  is_jump_exe,
  input  logic                  jump_exe,
  input  logic [ADDR_WIDTH-1:0] pc_target_exe,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
  } slot_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  slot_t                 id_q, id_d;
  slot_t                 exe_q, exe_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] exe_pred_next;
  logic [ADDR_WIDTH-1:0] pc_exe_plus4;
  logic [ADDR_WIDTH-1:0] actual_next;
  logic                  branch_resolved;

  assign pc_plus4        = pc_q + ADDR_WIDTH'(4);
  assign pc_exe_plus4    = pc_exe + ADDR_WIDTH'(4);
  // The predicted path is rebuilt from what the slot captured at fetch time,
  // so a stale or aliased pc_exe cannot mask a wrong prediction.
  assign exe_pred_next   = exe_q.pred_taken ? exe_q.pred_target
                                            : exe_q.pc + ADDR_WIDTH'(4);
  assign actual_next     = jump_exe ? pc_target_exe : pc_exe_plus4;
  assign branch_resolved = exe_q.valid & is_jump_exe;

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (exe_q.valid) begin
      if (is_jump_exe) begin
        if (exe_pred_next != actual_next) begin
          redirect    = 1'b1;
          redirect_pc = actual_next;
        end
      end else if (exe_q.pred_taken) begin
        // BTB alias on a non-branch: fall through to the sequential path.
        redirect    = 1'b1;
        redirect_pc = pc_exe_plus4;
      end
    end
  end

  assign flush = redirect;

  always_comb begin
    pc_d  = pc_q;
    id_d  = id_q;
    exe_d = exe_q;
    if (redirect) begin
      pc_d       = redirect_pc;
      id_d.valid = 1'b0;
      exe_d.valid = 1'b0;
    end else if (stall) begin
      exe_d.valid = 1'b0;
    end else begin
      pc_d             = jump_if ? pc_target_if : pc_plus4;
      id_d.valid       = 1'b1;
      id_d.pc          = pc_q;
      id_d.pred_taken  = jump_if;
      id_d.pred_target = pc_target_if;
      exe_d            = id_q;
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (branch_resolved && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
    if (redirect && (mispredict_cnt_q != '1)) begin
      mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q             <= RESET_PC;
      id_q             <= '0;
      exe_q            <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pc_q             <= pc_d;
      id_q             <= id_d;
      exe_q            <= exe_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign pc_if          = pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scenario bench for fetch_redirect_unit: expected fetch PCs are queued as each
// cycle's stimulus is driven and compared when the next cycle's pc_if appears.
module tb_fetch_redirect_unit;

  localparam int          AW = 64;
  localparam int          CW = 32;
  localparam logic [63:0] RPC = 64'h1000;

  logic          clk;
  logic          rstn;
  logic          stall;
  logic [AW-1:0] pc_if;
  logic          jump_if;
  logic [AW-1:0] pc_target_if;
  logic [AW-1:0] pc_exe;
  logic          is_jump_exe;
  logic          jump_exe;
  logic [AW-1:0] pc_target_exe;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          flush;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispredict_cnt;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_v;
  int            n_checks;
  int            n_pass;

  fetch_redirect_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .pc_if          (pc_if),
    .jump_if        (jump_if),
    .pc_target_if   (pc_target_if),
    .pc_exe         (pc_exe),
    .is_jump_exe    (is_jump_exe),
    .jump_exe       (jump_exe),
    .pc_target_exe  (pc_target_exe),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic set_idle();
    stall         = 1'b0;
    jump_if       = 1'b0;
    pc_target_if  = '0;
    pc_exe        = '0;
    is_jump_exe   = 1'b0;
    jump_exe      = 1'b0;
    pc_target_exe = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exe(input logic [AW-1:0] pc, input logic is_j, input logic taken,
                           input logic [AW-1:0] tgt);
    pc_exe        = pc;
    is_jump_exe   = is_j;
    jump_exe      = taken;
    pc_target_exe = tgt;
  endtask

  task automatic do_reset();
    set_idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    exp_q.delete();
  endtask

  // scenarios
  task automatic test_reset();
    set_idle();
    jump_if      = 1'b1;
    pc_target_if = 64'h5555;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (pc_if !== RPC) $display("FAIL reset_pc: got %h want %h", pc_if, RPC); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else n_pass++;
    n_checks++; if (redirect_pc !== 64'h0) $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); else n_pass++;
    n_checks++; if (branch_cnt !== 32'h0) $display("FAIL reset_branch_cnt: got %0d want 0", branch_cnt); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'h0) $display("FAIL reset_mispredict_cnt: got %0d want 0", mispredict_cnt); else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    exp_q.push_back(64'h1000);
    for (int i = 0; i < 2; i++) begin
      set_idle(); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL seq_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      n_checks++; if (redirect !== 1'b0) $display("FAIL seq_redirect: got %b want 0", redirect); else n_pass++;
      exp_q.push_back(64'h1004 + 64'(4 * i));
      tick();
    end
    // EXE now holds the RESET_PC fetch, captured valid at the first edge.
    drive_exe(64'h1000, 1'b1, 1'b0, 64'h0); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL seq_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL seq_redirect_nt: got %b want 0", redirect); else n_pass++;
    exp_q.push_back(64'h100C);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL seq_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (branch_cnt !== 32'd1) $display("FAIL seq_first_slot_valid: got %0d want 1", branch_cnt); else n_pass++;
  endtask

  task automatic test_predicted_taken();
    do_reset();
    exp_q.push_back(64'h1000);
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL pt_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h1004);
    tick();
    jump_if = 1'b1; pc_target_if = 64'h2000; #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL pt_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h2000);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL pt_pc_target: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h2004);
    tick();
    drive_exe(64'h1004, 1'b1, 1'b1, 64'h2000); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL pt_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL pt_redirect: got %b want 0", redirect); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL pt_flush: got %b want 0", flush); else n_pass++;
    exp_q.push_back(64'h2008);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL pt_no_bubble_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (branch_cnt !== 32'd1) $display("FAIL pt_branch_cnt: got %0d want 1", branch_cnt); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'd0) $display("FAIL pt_mispredict_cnt: got %0d want 0", mispredict_cnt); else n_pass++;
  endtask

  task automatic test_mispredict();
    do_reset();
    exp_q.push_back(64'h1000);
    for (int i = 0; i < 4; i++) begin
      set_idle(); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL mp_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      exp_q.push_back(64'h1004 + 64'(4 * i));
      tick();
    end
    drive_exe(64'h1008, 1'b1, 1'b1, 64'h3000); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL mp_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b1) $display("FAIL mp_redirect: got %b want 1", redirect); else n_pass++;
    n_checks++; if (flush !== 1'b1) $display("FAIL mp_flush: got %b want 1", flush); else n_pass++;
    n_checks++; if (redirect_pc !== 64'h3000) $display("FAIL mp_redirect_pc: got %h want 3000", redirect_pc); else n_pass++;
    exp_q.push_back(64'h3000);
    tick();
    // Would mispredict if the flushed slots were still valid.
    drive_exe(64'h100C, 1'b1, 1'b1, 64'h5000); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL mp_pc_redirected: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL mp_flushed_exe0: got %b want 0", redirect); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'd1) $display("FAIL mp_mispredict_cnt: got %0d want 1", mispredict_cnt); else n_pass++;
    exp_q.push_back(64'h3004);
    tick();
    #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL mp_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL mp_flushed_exe1: got %b want 0", redirect); else n_pass++;
    exp_q.push_back(64'h3008);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL mp_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (branch_cnt !== 32'd1) $display("FAIL mp_branch_cnt: got %0d want 1", branch_cnt); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'd1) $display("FAIL mp_mispredict_cnt_hold: got %0d want 1", mispredict_cnt); else n_pass++;
  endtask

  task automatic test_btb_alias();
    do_reset();
    exp_q.push_back(64'h1000);
    for (int i = 0; i < 3; i++) begin
      set_idle(); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL alias_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      exp_q.push_back(64'h1004 + 64'(4 * i));
      tick();
    end
    jump_if = 1'b1; pc_target_if = 64'h2000; #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL alias_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h2000);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL alias_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h2004);
    tick();
    drive_exe(64'h100C, 1'b0, 1'b0, 64'h0); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL alias_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b1) $display("FAIL alias_redirect: got %b want 1", redirect); else n_pass++;
    n_checks++; if (redirect_pc !== 64'h1010) $display("FAIL alias_redirect_pc: got %h want 1010", redirect_pc); else n_pass++;
    exp_q.push_back(64'h1010);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL alias_pc_fallthrough: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'd1) $display("FAIL alias_mispredict_cnt: got %0d want 1", mispredict_cnt); else n_pass++;
    n_checks++; if (branch_cnt !== 32'd0) $display("FAIL alias_branch_cnt: got %0d want 0", branch_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    // stall together with a redirect: the redirect wins
    do_reset();
    exp_q.push_back(64'h1000);
    for (int i = 0; i < 4; i++) begin
      set_idle(); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL stall_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      exp_q.push_back(64'h1004 + 64'(4 * i));
      tick();
    end
    stall = 1'b1;
    drive_exe(64'h1008, 1'b1, 1'b1, 64'h3000); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL stall_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b1) $display("FAIL stall_redirect: got %b want 1", redirect); else n_pass++;
    exp_q.push_back(64'h3000);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL stall_redirect_wins: got %h want %h", pc_if, exp_v); else n_pass++;

    // stall alone for two cycles
    do_reset();
    exp_q.push_back(64'h1000);
    for (int i = 0; i < 2; i++) begin
      set_idle(); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL stall_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      exp_q.push_back(64'h1004 + 64'(4 * i));
      tick();
    end
    stall = 1'b1; #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL stall_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h1008);
    tick();
    for (int i = 0; i < 2; i++) begin
      stall = 1'b1;
      drive_exe(64'h1004, 1'b1, 1'b1, 64'h7000); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL stall_hold_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      n_checks++; if (redirect !== 1'b0) $display("FAIL stall_bubble: got %b want 0", redirect); else n_pass++;
      exp_q.push_back(64'h1008);
      tick();
    end
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL stall_hold_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (branch_cnt !== 32'd0) $display("FAIL stall_branch_cnt: got %0d want 0", branch_cnt); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'd0) $display("FAIL stall_mispredict_cnt: got %0d want 0", mispredict_cnt); else n_pass++;
    exp_q.push_back(64'h100C);
    tick();
    #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL stall_release_pc: got %h want %h", pc_if, exp_v); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    exp_q.push_back(64'h1000);
    jump_if = 1'b1; pc_target_if = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL wrap_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL wrap_pc_top: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h0);
    tick();
    drive_exe(64'h1000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL wrap_pc_zero: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL wrap_redirect_a: got %b want 0", redirect); else n_pass++;
    exp_q.push_back(64'h4);
    tick();
    drive_exe(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'h1234); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL wrap_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL wrap_redirect_b: got %b want 0", redirect); else n_pass++;
    exp_q.push_back(64'h8);
    tick();
    set_idle(); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL wrap_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (branch_cnt !== 32'd2) $display("FAIL wrap_branch_cnt: got %0d want 2", branch_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back(64'h1000);
    for (int i = 0; i < 4; i++) begin
      set_idle(); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL ar_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      exp_q.push_back(64'h1004 + 64'(4 * i));
      tick();
    end
    drive_exe(64'h1008, 1'b1, 1'b1, 64'h3000); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL ar_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h3000);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_idle(); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (pc_if !== exp_v) $display("FAIL ar_pc: got %h want %h", pc_if, exp_v); else n_pass++;
      exp_q.push_back(64'h3004 + 64'(4 * i));
      tick();
    end
    drive_exe(64'h3000, 1'b1, 1'b1, 64'h4000); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL ar_pc: got %h want %h", pc_if, exp_v); else n_pass++;
    n_checks++; if (redirect !== 1'b1) $display("FAIL ar_redirect_pre: got %b want 1", redirect); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'd1) $display("FAIL ar_mispredict_pre: got %0d want 1", mispredict_cnt); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (pc_if !== RPC) $display("FAIL ar_pc_reset: got %h want %h", pc_if, RPC); else n_pass++;
    n_checks++; if (redirect !== 1'b0) $display("FAIL ar_redirect: got %b want 0", redirect); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL ar_flush: got %b want 0", flush); else n_pass++;
    n_checks++; if (redirect_pc !== 64'h0) $display("FAIL ar_redirect_pc: got %h want 0", redirect_pc); else n_pass++;
    n_checks++; if (branch_cnt !== 32'd0) $display("FAIL ar_branch_cnt: got %0d want 0", branch_cnt); else n_pass++;
    n_checks++; if (mispredict_cnt !== 32'd0) $display("FAIL ar_mispredict_cnt: got %0d want 0", mispredict_cnt); else n_pass++;
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    exp_q.push_back(RPC);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL ar_first_fetch: got %h want %h", pc_if, exp_v); else n_pass++;
    exp_q.push_back(64'h1004);
    tick();
    #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (pc_if !== exp_v) $display("FAIL ar_second_fetch: got %h want %h", pc_if, exp_v); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn     = 1'b1;
    set_idle();
    test_reset();
    test_sequential();
    test_predicted_taken();
    test_mispredict();
    test_btb_alias();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
